spi_peripheral: RTL and testbench

SPI_PERIPHERAL -- requirements
Module: spi_peripheral

---
 rtl/spi_pkg.sv | 18 +
 rtl/spi_peripheral_if.sv | 20 ++
 rtl/sync_ff.sv | 19 +
 rtl/spi_peripheral.sv | 95 +++++++++
 tb/tb_spi_peripheral.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI register-write peripheral.
package spi_pkg;
    localparam int FRAME_W = 16;
    localparam int CNT_W   = 5;
    localparam logic [CNT_W-1:0] CNT_SAT = 5'd17;

    localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [6:0] ADDR_DUTY      = 7'h04;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        COMMIT
    } spi_state_t;
endpackage

// File: rtl/spi_peripheral_if.sv
// SPI pin bundle plus the register outputs, shared by the controller side and the peripheral.
interface spi_peripheral_if;
    logic       sclk;
    logic       copi;
    logic       ncs;
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;

    modport master (
        output sclk, copi, ncs,
        input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle
    );
    modport slave (
        input  sclk, copi, ncs,
        output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle
    );
endinterface

// File: rtl/sync_ff.sv
// Multi-flop synchronizer with configurable depth and reset value.
module sync_ff #(
    parameter int   DEPTH   = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [DEPTH-1:0] stg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stg <= {DEPTH{RST_VAL}};
        else        stg <= {stg[DEPTH-2:0], d};
    end

    assign q = stg[DEPTH-1];
endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 write-only register block: 16-bit frames {rw, addr[6:0], data[7:0]}
// commit into five 8-bit control registers once chip select deasserts.
module spi_peripheral
    import spi_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [6:0] MAX_ADDR    = 7'h04
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle
);
    logic sclk_s, copi_s, ncs_s;
    logic sclk_d, ncs_d;

    sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst_n(rst_n), .d(sclk), .q(sclk_s));
    sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (.clk(clk), .rst_n(rst_n), .d(copi), .q(copi_s));
    sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs  (.clk(clk), .rst_n(rst_n), .d(ncs),  .q(ncs_s));

    // The ncs chain shows its reset value for SYNC_STAGES cycles after release;
    // a falling edge is only trusted once a real high level has been seen.
    logic [SYNC_STAGES-1:0] flush;
    logic                   armed;

    wire sclk_rise = sclk_s & ~sclk_d & ~ncs_s;
    wire ncs_fall  = ~ncs_s & ncs_d & armed;
    wire ncs_rise  = ncs_s & ~ncs_d;

    spi_state_t           state;
    logic [CNT_W-1:0]     cnt;
    logic [FRAME_W-1:0]   shreg;
    wire  [6:0]           addr = shreg[14:8];
    wire                  wr_ok = (cnt == CNT_W'(FRAME_W)) && shreg[FRAME_W-1] && (addr <= MAX_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_d          <= 1'b0;
            ncs_d           <= 1'b1;
            flush           <= '0;
            armed           <= 1'b0;
            state           <= IDLE;
            cnt             <= '0;
            shreg           <= '0;
            en_reg_out_7_0  <= 8'h00;
            en_reg_out_15_8 <= 8'h00;
            en_reg_pwm_7_0  <= 8'h00;
            en_reg_pwm_15_8 <= 8'h00;
            pwm_duty_cycle  <= 8'h00;
        end else begin
            sclk_d <= sclk_s;
            ncs_d  <= ncs_s;
            flush  <= {flush[SYNC_STAGES-2:0], 1'b1};
            if (flush[SYNC_STAGES-1] && ncs_s) armed <= 1'b1;

            case (state)
                IDLE: begin
                    if (ncs_fall) begin
                        state <= RECV;
                        cnt   <= '0;
                        shreg <= '0;
                    end
                end
                RECV: begin
                    if (ncs_rise) begin
                        state <= COMMIT;
                    end else if (sclk_rise) begin
                        shreg <= {shreg[FRAME_W-2:0], copi_s};
                        if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
                    end
                end
                COMMIT: begin
                    state <= IDLE;
                    if (wr_ok) begin
                        case (addr)
                            ADDR_EN_OUT_LO: en_reg_out_7_0  <= shreg[7:0];
                            ADDR_EN_OUT_HI: en_reg_out_15_8 <= shreg[7:0];
                            ADDR_EN_PWM_LO: en_reg_pwm_7_0  <= shreg[7:0];
                            ADDR_EN_PWM_HI: en_reg_pwm_15_8 <= shreg[7:0];
                            ADDR_DUTY:      pwm_duty_cycle  <= shreg[7:0];
                            default: ;
                        endcase
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_peripheral.sv
// Randomized bench for spi_peripheral against a register-map model driven by frame rules.
module tb_spi_peripheral;
    localparam int SYNC = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_peripheral_if bus ();

    spi_peripheral #(.SYNC_STAGES(SYNC), .MAX_ADDR(7'h04)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sclk            (bus.sclk),
        .copi            (bus.copi),
        .ncs             (bus.ncs),
        .en_reg_out_7_0  (bus.en_reg_out_7_0),
        .en_reg_out_15_8 (bus.en_reg_out_15_8),
        .en_reg_pwm_7_0  (bus.en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (bus.en_reg_pwm_15_8),
        .pwm_duty_cycle  (bus.pwm_duty_cycle)
    );

    int n_chk  = 0;
    int n_fail = 0;
    logic [7:0] exp_reg [5];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".out_lo"}, 32'(bus.en_reg_out_7_0),  32'(exp_reg[0]));
        chk({tag, ".out_hi"}, 32'(bus.en_reg_out_15_8), 32'(exp_reg[1]));
        chk({tag, ".pwm_lo"}, 32'(bus.en_reg_pwm_7_0),  32'(exp_reg[2]));
        chk({tag, ".pwm_hi"}, 32'(bus.en_reg_pwm_15_8), 32'(exp_reg[3]));
        chk({tag, ".duty"},   32'(bus.pwm_duty_cycle),  32'(exp_reg[4]));
    endtask

    // Only a complete 16-bit write to a mapped address lands in the register map.
    task automatic model_frame(input logic [31:0] w, input int nbits);
        int a;
        a = int'(w[14:8]);
        if (nbits == 16 && w[15] && a <= 4) exp_reg[a] = w[7:0];
    endtask

    task automatic shift_bits(input logic [31:0] w, input int nbits, input int half);
        for (int i = nbits - 1; i >= 0; i--) begin
            bus.copi = w[i];
            repeat (half) @(negedge clk);
            bus.sclk = 1'b1;
            repeat (half) @(negedge clk);
            bus.sclk = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [31:0] w, input int nbits, input int half);
        bus.ncs = 1'b0;
        repeat (half) @(negedge clk);
        shift_bits(w, nbits, half);
        repeat (half) @(negedge clk);
        bus.ncs = 1'b1;
        model_frame(w, nbits);
    endtask

    // Commit must be visible SYNC+2 clk edges after raw ncs rises.
    task automatic commit_check(input string tag);
        repeat (SYNC + 2) @(posedge clk);
        #1;
        chk_all(tag);
        @(negedge clk);
    endtask

    initial begin
        bus.sclk = 1'b0;
        bus.copi = 1'b0;
        bus.ncs  = 1'b1;
        for (int i = 0; i < 5; i++) exp_reg[i] = 8'h00;
        repeat (3) @(negedge clk);
        chk_all("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        send_frame(32'h80F0, 16, 3);
        commit_check("w_out_lo");

        send_frame(32'h0455, 16, 3);
        commit_check("read_frame");
        send_frame(32'h85AA, 16, 4);
        commit_check("addr5");

        send_frame(32'h833C >> 1, 15, 3);
        commit_check("short15");
        send_frame((32'h833C << 1) | 32'h1, 17, 3);
        commit_check("long17");
        send_frame(32'h833C, 16, 3);
        commit_check("w_pwm_hi");

        // Reset in the middle of a frame; the tail must never commit.
        bus.ncs = 1'b0;
        repeat (3) @(negedge clk);
        shift_bits(32'h84, 8, 3);
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) exp_reg[i] = 8'h00;
        #1;
        chk_all("rst_async");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        shift_bits(32'hFF, 8, 3);
        repeat (3) @(negedge clk);
        bus.ncs = 1'b1;
        commit_check("rst_mid");
        send_frame(32'h8480, 16, 3);
        commit_check("after_rst");

        send_frame(32'h8201, 16, 3);
        repeat (3) @(negedge clk);
        send_frame(32'h8302, 16, 3);
        repeat (3) @(negedge clk);
        send_frame(32'h8403, 16, 3);
        commit_check("b2b");

        for (int n = 0; n < 40; n++) begin
            logic [15:0] f;
            logic [31:0] w;
            int nb, sel, half;
            f = {($urandom_range(0, 3) != 0), 7'($urandom_range(0, 7)), 8'($urandom)};
            sel = $urandom_range(0, 4);
            nb = (sel == 0) ? 15 : (sel == 4) ? 17 : 16;
            w = (nb == 15) ? 32'(f >> 1) : (nb == 17) ? {15'h0, f, 1'($urandom)} : 32'(f);
            half = $urandom_range(3, 5);
            send_frame(w, nb, half);
            commit_check($sformatf("rnd%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
